radix2_sdf_stage_ctrl: RTL and testbench

//  Sequencer for one single-path delay-feedback (SDF) radix-2 stage of the streaming FFT.

---
 rtl/radix2_sdf_stage_ctrl.sv | 159 +++++++++++++++
 tb/tb_radix2_sdf_stage_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix2_sdf_stage_ctrl.sv
// rtl/radix2_sdf_stage_ctrl.sv - sequencer for one radix-2 single-path delay-feedback FFT stage
// Optional feature: define RADIX2_SDF_OVERLAP_EN to accept the next frame's first half during DRAIN.
module radix2_sdf_stage_ctrl #(
    parameter int N      = 16,
    parameter int STAGE  = 0,
    parameter int BF_LAT = 3,
    parameter int AW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sop,
    output logic          in_ready,
    output logic          buf_wr,
    output logic          fb_rd,
    output logic          bf_ce,
    output logic [AW-1:0] tw_addr,
    output logic          out_sel,
    output logic          out_valid,
    output logic          out_sop,
    output logic          out_eop,
    output logic          err_sop
);
    localparam int SPAN = N >> (STAGE + 1);
    localparam int HB   = $clog2(SPAN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
    localparam logic [AW-1:0] SPAN_V   = AW'(SPAN);
    localparam logic [AW-1:0] KMASK    = AW'(SPAN - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] drain_q, drain_d;
    logic [3:0]    pipe_q [BF_LAT];
    logic [3:0]    pipe_d [BF_LAT];

    logic accept;
    logic idx_hi;
    logic emit, emit_sel, emit_sop, emit_eop;

    // idx >= 2*SPAN: any bit above the half bit is set
    assign idx_hi = (idx_q >> (HB + 1)) != '0;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        buf_wr   = 1'b0;
        fb_rd    = 1'b0;
        bf_ce    = 1'b0;
        tw_addr  = '0;
        err_sop  = 1'b0;
        emit     = 1'b0;
        emit_sel = 1'b0;
        emit_sop = 1'b0;
        emit_eop = 1'b0;
`ifdef RADIX2_SDF_OVERLAP_EN
        in_ready = (state_q != S_DRAIN) || (idx_q < SPAN_V);
`else
        in_ready = (state_q != S_DRAIN);
`endif
        // gating with rst keeps every strobe low while reset is held
        accept = in_valid & in_ready & rst;

        case (state_q)
            S_IDLE: begin
                if (accept && in_sop) begin
                    buf_wr  = 1'b1;
                    idx_d   = ONE;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (in_sop && idx_q != '0) begin
                        err_sop = 1'b1;
                        buf_wr  = 1'b1;
                        idx_d   = ONE;
                    end else begin
                        if (!idx_q[HB]) begin
                            buf_wr = 1'b1;
                            if (idx_hi) begin
                                fb_rd    = 1'b1;
                                emit     = 1'b1;
                                emit_sel = 1'b1;
                            end
                        end else begin
                            bf_ce    = 1'b1;
                            tw_addr  = (idx_q & KMASK) << STAGE;
                            emit     = 1'b1;
                            emit_sop = (idx_q == SPAN_V);
                        end
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            drain_d = SPAN_V;
                            state_d = S_DRAIN;
                        end else begin
                            idx_d = idx_q + ONE;
                        end
                    end
                end
            end
            S_DRAIN: begin
                fb_rd    = 1'b1;
                emit     = 1'b1;
                emit_sel = 1'b1;
                emit_eop = (drain_q == ONE);
                drain_d  = drain_q - ONE;
`ifdef RADIX2_SDF_OVERLAP_EN
                if (accept) begin
                    if (in_sop) begin
                        err_sop = (idx_q != '0);
                        buf_wr  = 1'b1;
                        idx_d   = ONE;
                    end else if (idx_q != '0) begin
                        buf_wr = 1'b1;
                        idx_d  = idx_q + ONE;
                    end
                end
`endif
                if (drain_q == ONE) begin
                    state_d = (idx_d != '0) ? S_RUN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pipe_d[0] = {emit, emit_sel, emit_sop, emit_eop};
        for (int i = 1; i < BF_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            drain_q <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            for (int i = 0; i < BF_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign {out_valid, out_sel, out_sop, out_eop} = pipe_q[BF_LAT-1];

endmodule

// File: tb/tb_radix2_sdf_stage_ctrl.sv
// tb/tb_radix2_sdf_stage_ctrl.sv - self-checking bench for radix2_sdf_stage_ctrl (STAGE 0 and 1 side by side)
module tb_radix2_sdf_stage_ctrl;
    localparam int N      = 16;
    localparam int BF_LAT = 3;
    localparam int AW     = $clog2(N);
`ifdef RADIX2_SDF_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_sop = 1'b0;
    logic rdy [2];
    logic wr [2];
    logic fb [2];
    logic ce [2];
    logic osel [2];
    logic oval [2];
    logic osop [2];
    logic oeop [2];
    logic err [2];
    logic [AW-1:0] tw [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        radix2_sdf_stage_ctrl #(.N(N), .STAGE(g), .BF_LAT(BF_LAT)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
            .in_ready(rdy[g]), .buf_wr(wr[g]), .fb_rd(fb[g]), .bf_ce(ce[g]),
            .tw_addr(tw[g]), .out_sel(osel[g]), .out_valid(oval[g]),
            .out_sop(osop[g]), .out_eop(oeop[g]), .err_sop(err[g])
        );
    end

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference model: samples taken in the current frame, drain beats still owed,
    // and output beats {valid,sel,sop,eop} scheduled by the cycle they must appear
    int m_pos [2];
    int m_drain [2];
    logic [3:0] sched [2][16];

    int beats, run, maxrun, eop_cyc, err_cnt, sop_after_eop, rdy0_low, rdy1_low;
    logic prev_eop;
    int tw1_q [$];

    typedef struct {
        logic v, s;
        logic rdy, wr, fb, ce;
        int tw;
        logic [3:0] beat;
    } vec_t;
    vec_t tbl [32];

    task automatic chk(input int d, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", name, d, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pos[d] = 0;
            m_drain[d] = 0;
            for (int j = 0; j < 16; j++) sched[d][j] = 4'b0;
        end
    endtask

    task automatic clr_stats();
        beats = 0; run = 0; maxrun = 0; eop_cyc = -1; err_cnt = 0;
        sop_after_eop = 0; rdy0_low = 0; rdy1_low = 0; prev_eop = 1'b0;
        tw1_q.delete();
    endtask

    task automatic drive_check(input logic v, input logic s);
        in_valid = v;
        in_sop = s;
        #3;
        for (int d = 0; d < 2; d++) begin
            int span, i, e_tw;
            bit ready, acc, e_wr, e_fb, e_ce, e_err;
            logic [3:0] beat;
            span = N >> (d + 1);
            ready = (m_drain[d] == 0) || (OVL && m_pos[d] < span);
            acc = v && ready;
            e_wr = 0; e_fb = 0; e_ce = 0; e_err = 0; e_tw = 0; beat = 4'b0; i = -1;
            if (m_drain[d] > 0) begin
                e_fb = 1;
                beat = {1'b1, 1'b1, 1'b0, m_drain[d] == 1};
                m_drain[d]--;
            end
            if (acc) begin
                if (s) begin
                    e_err = (m_pos[d] != 0);
                    i = 0;
                end else if (m_pos[d] != 0) begin
                    i = m_pos[d];
                end
            end
            if (i >= 0) begin
                if (((i / span) % 2) == 0) begin
                    e_wr = 1;
                    if (i >= 2 * span) begin
                        e_fb = 1;
                        beat = 4'b1100;
                    end
                end else begin
                    e_ce = 1;
                    e_tw = (i % span) * (1 << d);
                    beat = {1'b1, 1'b0, i == span, 1'b0};
                end
                m_pos[d] = i + 1;
                if (m_pos[d] == N) begin
                    m_pos[d] = 0;
                    m_drain[d] = span;
                end
            end
            chk(d, "in_ready", rdy[d], ready);
            chk(d, "buf_wr", wr[d], e_wr);
            chk(d, "fb_rd", fb[d], e_fb);
            chk(d, "bf_ce", ce[d], e_ce);
            chk(d, "tw_addr", tw[d], e_ce ? e_tw : 0);
            chk(d, "err_sop", err[d], e_err);
            chk(d, "out_beat", {oval[d], osel[d], osop[d], oeop[d]}, sched[d][cyc % 16]);
            sched[d][cyc % 16] = 4'b0;
            sched[d][(cyc + BF_LAT) % 16] = beat;
        end
        if (oval[0]) begin
            beats++;
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
        if (oeop[0]) eop_cyc = cyc;
        if (osop[0] && prev_eop) sop_after_eop++;
        prev_eop = oeop[0];
        if (err[0]) err_cnt++;
        if (!rdy[0]) rdy0_low++;
        if (!rdy[1]) rdy1_low++;
        if (ce[1]) tw1_q.push_back(int'(tw[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step(input logic v, input logic s);
        drive_check(v, s);
        tick();
    endtask

    task automatic frame(input int n_samples, input logic with_sop);
        for (int j = 0; j < n_samples; j++) step(1'b1, with_sop && j == 0);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0);
    endtask

    task automatic chk_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_in_ready", rdy[d], 1);
            chk(d, "rst_strobes", {wr[d], fb[d], ce[d], err[d]}, 0);
            chk(d, "rst_tw_addr", tw[d], 0);
            chk(d, "rst_out", {oval[d], osel[d], osop[d], oeop[d]}, 0);
        end
    endtask

    initial begin
        int c0;
        int oc;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b1;
        model_reset();
        clr_stats();

        // one STAGE-0 frame written out cycle by cycle from the frame schedule
        for (int c = 0; c < 32; c++) begin
            oc = c - BF_LAT;
            tbl[c].v    = (c < 16);
            tbl[c].s    = (c == 0);
            tbl[c].rdy  = OVL || !(c >= 16 && c < 24);
            tbl[c].wr   = (c < 8);
            tbl[c].ce   = (c >= 8 && c < 16);
            tbl[c].tw   = (c >= 8 && c < 16) ? c - 8 : 0;
            tbl[c].fb   = (c >= 16 && c < 24);
            tbl[c].beat = {oc >= 8 && oc < 24, oc >= 16 && oc < 24, oc == 8, oc == 23};
        end
        for (int c = 0; c < 32; c++) begin
            drive_check(tbl[c].v, tbl[c].s);
            chk(0, "tbl_in_ready", rdy[0], tbl[c].rdy);
            chk(0, "tbl_buf_wr", wr[0], tbl[c].wr);
            chk(0, "tbl_fb_rd", fb[0], tbl[c].fb);
            chk(0, "tbl_bf_ce", ce[0], tbl[c].ce);
            chk(0, "tbl_tw_addr", tw[0], tbl[c].tw);
            chk(0, "tbl_out_beat", {oval[0], osel[0], osop[0], oeop[0]}, tbl[c].beat);
            tick();
        end
        chk(0, "frame_beats", beats, 16);
        chk(0, "ready_low_cycles", rdy0_low, OVL ? 0 : 8);
        chk(1, "ready_low_cycles", rdy1_low, OVL ? 0 : 4);
        chk(1, "tw_count", tw1_q.size(), 8);
        for (int j = 0; j < 8; j++) begin
            chk(1, "tw_seq", (j < tw1_q.size()) ? tw1_q[j] : -1, (2 * j) % 8);
        end

        // three stall cycles after five accepted samples
        clr_stats();
        c0 = cyc;
        frame(5, 1'b1);
        idle(3);
        frame(11, 1'b0);
        idle(15);
        chk(0, "stall_beats", beats, 16);
        chk(0, "stall_eop_cycle", eop_cyc, c0 + 26 + BF_LAT);

        // resync: new sop arrives when idx=6
        clr_stats();
        c0 = cyc;
        frame(6, 1'b1);
        step(1'b1, 1'b1);
        frame(15, 1'b0);
        idle(15);
        chk(0, "resync_err_pulses", err_cnt, 1);
        chk(0, "resync_beats", beats, 16);
        chk(0, "resync_eop_cycle", eop_cyc, c0 + 29 + BF_LAT);

        // two frames offered back to back
        clr_stats();
        frame(16, 1'b1);
        frame(16, 1'b1);
        idle(30);
        chk(0, "b2b_beats", beats, OVL ? 32 : 16);
        chk(0, "b2b_contiguous", maxrun, OVL ? 32 : 16);
        chk(0, "b2b_sop_after_eop", sop_after_eop, OVL ? 1 : 0);
        chk(0, "b2b_ready_low", rdy0_low, OVL ? 0 : 8);

        // sop held through the drain, including its last cycle
        clr_stats();
        frame(16, 1'b1);
        for (int j = 0; j < 7; j++) step(1'b1, 1'b1);
        drive_check(1'b1, 1'b1);
        chk(0, "drain_end_sop_wr", wr[0], OVL ? 1 : 0);
        tick();
        drive_check(1'b1, 1'b1);
        chk(0, "after_drain_sop_wr", wr[0], 1);
        tick();
        frame(15, 1'b0);
        idle(20);

        // random traffic against the model
        for (int j = 0; j < 3000; j++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0);
        end
        idle(20);

        // asynchronous reset in the middle of a frame
        frame(11, 1'b1);
        in_valid = 1'b1;
        in_sop = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b1;
        cyc++;
        model_reset();
        clr_stats();
        frame(16, 1'b1);
        idle(15);
        chk(0, "post_reset_beats", beats, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
